// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared types and encodings for the multicycle MIPS-subset control unit.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: state enum (4 bit), instruction classes, opcode/funct constants,
//   mux-select and alu_ctrl encodings, packed control word.
// Build option: OVERFLOW_TRAP_EN adds the OVF state.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_BRANCH   = 4'd7,
    S_JUMP     = 4'd8,
    S_MEM_ADDR = 4'd9,
    S_MEM_RD   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_MEM_WB   = 4'd12
`ifdef OVERFLOW_TRAP_EN
    , S_OVF    = 4'd13
`endif
  } state_t;

  typedef enum logic [2:0] {C_ILL, C_R, C_I, C_BR, C_J, C_MEM, C_RST} iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3;
  localparam logic [2:0] IORD_PC = 3'd0, IORD_ALUOUT = 3'd1;
  localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1;
  localparam logic [3:0] DSRC_ALUOUT = 4'd0, DSRC_MDR = 4'd1;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_A = 2'd1;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM2 = 2'd3;
  localparam logic [2:0] PCS_ALU = 3'd0, PCS_ALUOUT = 3'd1, PCS_JUMP = 3'd2, PCS_EXC = 3'd3;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_wr;
    logic       epc_write;
    logic [2:0] iord;
    logic [1:0] reg_dst;
    logic [3:0] data_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [2:0] pc_source;
    logic       reset_out;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purpose : classify opcode/funct into an instruction class, R-type alu_ctrl and illegal flag.
// Latency : combinational.
// Backpressure: none.
// Ports: opcode, funct in; iclass, alu_ctrl, alt (BNE among branches, SW among
//   memory ops), ovf_chk (result can trap on signed overflow), illegal out.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] alu_ctrl,
  output logic       alt,
  output logic       ovf_chk,
  output logic       illegal
);

  always_comb begin
    iclass   = C_ILL;
    alu_ctrl = ALU_ADD;
    alt      = 1'b0;
    ovf_chk  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin iclass = C_R; ovf_chk = 1'b1; end
          FN_SUB:  begin iclass = C_R; ovf_chk = 1'b1; alu_ctrl = ALU_SUB; end
          FN_AND:  begin iclass = C_R; alu_ctrl = ALU_AND; end
          default: iclass = C_ILL;
        endcase
      end
      OP_ADDI: begin iclass = C_I; ovf_chk = 1'b1; end
      OP_BEQ:  iclass = C_BR;
      OP_BNE:  begin iclass = C_BR; alt = 1'b1; end
      OP_J:    iclass = C_J;
      OP_LW:   iclass = C_MEM;
      OP_SW:   begin iclass = C_MEM; alt = 1'b1; end
      OP_HALT: iclass = C_RST;
      default: iclass = C_ILL;
    endcase
    illegal = (iclass == C_ILL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Purpose : multicycle MIPS-subset control FSM driving datapath selects/enables.
// Latency : outputs registered from the next state; only BRANCH pc_write (zr) and
//   WB reg_write (ofw, OVERFLOW_TRAP_EN) are gated combinationally. No backpressure;
//   memory latency is covered by MEM_WAIT fixed wait cycles.
// Ports: clk, reset (sync, active-high), opcode/funct (IR fields), zr/ofw ALU flags,
//   gt/lt/eq/ng reserved; enables, mux selects, alu_ctrl, reset_out, illegal_op, state_dbg.
// Build option: OVERFLOW_TRAP_EN enables the signed-overflow trap (OVF state, epc_write).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT     = 2,
  parameter int unsigned RESET_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zr,
  input  logic       ofw,
  input  logic       gt,
  input  logic       lt,
  input  logic       eq,
  input  logic       ng,
  output logic       pc_write,
  output logic       ir_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       mem_wr,
  output logic       epc_write,
  output logic [2:0] iord,
  output logic [1:0] reg_dst,
  output logic [3:0] data_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [2:0] pc_source,
  output logic       reset_out,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [2:0] MW = 3'(MEM_WAIT);
  localparam logic [3:0] RC = 4'(RESET_CYCLES);

  state_t     state, nstate;
  logic [2:0] wcnt, nwcnt;   // wait counter for FETCH / MEM_RD / MEM_WR
  logic [3:0] rcnt, nrcnt;   // cycles spent in RESET with reset released
  ctrl_t      ctl_q, ctl_d;
  logic       alt_q, chk_q;  // instruction variant flags captured in DECODE
  iclass_t    iclass;
  logic [2:0] dec_alu;
  logic       dec_alt, dec_chk, dec_ill;
  logic       trap;

  mc_ctrl_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (iclass),
    .alu_ctrl (dec_alu),
    .alt      (dec_alt),
    .ovf_chk  (dec_chk),
    .illegal  (dec_ill)
  );

`ifdef OVERFLOW_TRAP_EN
  assign trap = (state == S_WB_R || state == S_WB_I) && chk_q && ofw;
  logic unused_in;
  assign unused_in = ^{gt, lt, eq, ng};
`else
  assign trap = 1'b0;
  logic unused_in;
  assign unused_in = ^{gt, lt, eq, ng, ofw, chk_q};
`endif

  always_comb begin
    nstate = state;
    case (state)
      S_RESET:  if (rcnt == RC) nstate = S_FETCH;
      S_FETCH:  if (wcnt == MW) nstate = S_DECODE;
      S_DECODE: begin
        case (iclass)
          C_R:     nstate = S_EXEC_R;
          C_I:     nstate = S_EXEC_I;
          C_BR:    nstate = S_BRANCH;
          C_J:     nstate = S_JUMP;
          C_MEM:   nstate = S_MEM_ADDR;
          C_RST:   nstate = S_RESET;
          default: nstate = S_FETCH;
        endcase
      end
      S_EXEC_R:   nstate = S_WB_R;
      S_EXEC_I:   nstate = S_WB_I;
`ifdef OVERFLOW_TRAP_EN
      S_WB_R, S_WB_I: nstate = trap ? S_OVF : S_FETCH;
`endif
      S_MEM_ADDR: nstate = alt_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (wcnt == MW) nstate = S_MEM_WB;
      S_MEM_WR:   if (wcnt == MW) nstate = S_FETCH;
      default:    nstate = S_FETCH;
    endcase
    if (reset) nstate = S_RESET;

    // Counters clear on every state entry; each only runs where it is meaningful.
    nwcnt = 3'd0;
    nrcnt = 4'd0;
    if (nstate == state && !reset) begin
      if (state == S_RESET) nrcnt = rcnt + 4'd1;
      else                  nwcnt = wcnt + 3'd1;
    end

    // Control word for the cycle after this edge.
    ctl_d = '0;
    case (nstate)
      S_RESET: begin
        ctl_d.reset_out = 1'b1;
        ctl_d.alu_ctrl  = ALU_PASS;
      end
      S_FETCH: begin
        ctl_d.iord       = IORD_PC;
        ctl_d.alu_src_a  = SRCA_PC;
        ctl_d.alu_src_b  = SRCB_4;
        ctl_d.alu_ctrl   = ALU_ADD;
        ctl_d.pc_source  = PCS_ALU;
        ctl_d.pc_write   = (nwcnt == MW);
        ctl_d.ir_write   = (nwcnt == MW);
        // Illegal report lands in the first FETCH cycle after the failed decode.
        ctl_d.illegal_op = (state == S_DECODE) && dec_ill;
      end
      S_DECODE: begin
        ctl_d.ab_write      = 1'b1;
        ctl_d.alu_src_a     = SRCA_PC;
        ctl_d.alu_src_b     = SRCB_IMM2;
        ctl_d.alu_ctrl      = ALU_ADD;
        ctl_d.alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        ctl_d.alu_src_a     = SRCA_A;
        ctl_d.alu_src_b     = SRCB_B;
        ctl_d.alu_ctrl      = dec_alu;
        ctl_d.alu_out_write = 1'b1;
      end
      S_WB_R: begin
        ctl_d.reg_dst   = REGDST_RD;
        ctl_d.data_src  = DSRC_ALUOUT;
        ctl_d.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctl_d.alu_src_a     = SRCA_A;
        ctl_d.alu_src_b     = SRCB_IMM;
        ctl_d.alu_ctrl      = ALU_ADD;
        ctl_d.alu_out_write = 1'b1;
      end
      S_WB_I: begin
        ctl_d.reg_dst   = REGDST_RT;
        ctl_d.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl_d.alu_src_a = SRCA_A;
        ctl_d.alu_src_b = SRCB_B;
        ctl_d.alu_ctrl  = ALU_SUB;
        ctl_d.pc_source = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctl_d.pc_source = PCS_JUMP;
        ctl_d.pc_write  = 1'b1;
      end
      S_MEM_RD: ctl_d.iord = IORD_ALUOUT;
      S_MEM_WR: begin
        ctl_d.iord   = IORD_ALUOUT;
        ctl_d.mem_wr = 1'b1;
      end
      S_MEM_WB: begin
        ctl_d.reg_dst   = REGDST_RT;
        ctl_d.data_src  = DSRC_MDR;
        ctl_d.reg_write = 1'b1;
      end
`ifdef OVERFLOW_TRAP_EN
      S_OVF: begin
        ctl_d.epc_write = 1'b1;
        ctl_d.pc_source = PCS_EXC;
        ctl_d.pc_write  = 1'b1;
      end
`endif
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    state <= nstate;
    wcnt  <= nwcnt;
    rcnt  <= nrcnt;
    ctl_q <= ctl_d;
    if (reset) begin
      alt_q <= 1'b0;
      chk_q <= 1'b0;
    end else if (state == S_DECODE) begin
      alt_q <= dec_alt;
      chk_q <= dec_chk;
    end
  end

  always_ff @(posedge clk) begin
    assert (MEM_WAIT <= 7 && RESET_CYCLES >= 1 && RESET_CYCLES <= 15)
      else $error("mc_ctrl_fsm: MEM_WAIT or RESET_CYCLES out of range");
  end

  // alt_q selects BNE: branch taken on !zr instead of zr.
  assign pc_write      = ctl_q.pc_write | ((state == S_BRANCH) & (zr ^ alt_q));
  assign reg_write     = ctl_q.reg_write & ~trap;
  assign ir_write      = ctl_q.ir_write;
  assign ab_write      = ctl_q.ab_write;
  assign alu_out_write = ctl_q.alu_out_write;
  assign mem_wr        = ctl_q.mem_wr;
  assign epc_write     = ctl_q.epc_write;
  assign iord          = ctl_q.iord;
  assign reg_dst       = ctl_q.reg_dst;
  assign data_src      = ctl_q.data_src;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign alu_ctrl      = ctl_q.alu_ctrl;
  assign pc_source     = ctl_q.pc_source;
  assign reset_out     = ctl_q.reset_out;
  assign illegal_op    = ctl_q.illegal_op;
  assign state_dbg     = state;

endmodule
